alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters. A round-robin arbiter
// grants one request at a time. The winner's operands are registered and
// driven to the ALU. The ALU result is captured one cycle later and held
// on the shared response bus until the winning requester takes it.

module alu_share_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    // request side
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [2*DATA_W-1:0]   i_req_op_a,
    input  logic [2*DATA_W-1:0]   i_req_op_b,
    input  logic [5:0]            i_req_alu_op,
    input  logic [3:0]            i_req_alu_shift,

    // response side
    output logic [1:0]            o_rsp_valid,
    input  logic [1:0]            i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_data,
    output logic                  o_rsp_zero,

    // shared ALU
    output logic [DATA_W-1:0]     o_alu_op_a,
    output logic [DATA_W-1:0]     o_alu_op_b,
    output logic [2:0]            o_alu_op,
    output logic [1:0]            o_alu_shift,
    input  logic [DATA_W-1:0]     i_alu_out,
    input  logic                  i_alu_zero,

    output logic                  o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Round-robin pointer: index of the most recently granted requester.
    logic last_gnt;
    // Requester that owns the operation currently in flight.
    logic win_idx;

    // Operand stage: registered ALU inputs.
    logic [DATA_W-1:0] op_a_p0;
    logic [DATA_W-1:0] op_b_p0;
    logic [2:0]        alu_op_p0;
    logic [1:0]        alu_shift_p0;

    // Result stage: captured ALU outputs.
    logic [DATA_W-1:0] rsp_data_p1;
    logic              rsp_zero_p1;

    // Arbitration signals.
    logic              accept;
    logic              grant_idx;
    logic [DATA_W-1:0] sel_op_a;
    logic [DATA_W-1:0] sel_op_b;
    logic [2:0]        sel_alu_op;
    logic [1:0]        sel_alu_shift;

    // Round-robin choice. On a tie, the requester that did not win last
    // time is granted. Otherwise the single active requester is granted.
    // The result for an all-idle input is unused.
    function automatic logic pick_winner(input logic [1:0] valid, input logic last);
        logic win;
        if (valid == 2'b11) begin
            win = ~last;
        end else begin
            win = valid[1];
        end
        return win;
    endfunction

    assign accept    = (state == IDLE) && (|i_req_valid);
    assign grant_idx = pick_winner(i_req_valid, last_gnt);

    // Mux the winner's request fields out of the packed request buses.
    always_comb begin
        sel_op_a      = grant_idx ? i_req_op_a[2*DATA_W-1:DATA_W] : i_req_op_a[DATA_W-1:0];
        sel_op_b      = grant_idx ? i_req_op_b[2*DATA_W-1:DATA_W] : i_req_op_b[DATA_W-1:0];
        sel_alu_op    = grant_idx ? i_req_alu_op[5:3]             : i_req_alu_op[2:0];
        sel_alu_shift = grant_idx ? i_req_alu_shift[3:2]          : i_req_alu_shift[1:0];
    end

    // Grant exactly one requester while idle. Force no grant while reset is
    // held, because the asynchronous reset alone leaves the state in IDLE.
    always_comb begin
        o_req_ready = 2'b00;
        if (accept && i_rst_n) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic: each operation passes IDLE -> EXEC -> RESP
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|i_req_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                // Only the owner of the result can complete the handshake.
                if (i_rsp_ready[win_idx]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Track the arbitration pointer and the owner of the in-flight operation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt <= 1'b1;
            win_idx  <= 1'b0;
        end else if (accept) begin
            last_gnt <= grant_idx;
            win_idx  <= grant_idx;
        end
    end

    // ---- operand stage (p0): capture the winner's request on acceptance ----
    // Load the operand registers with the granted request
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_a_p0      <= '0;
            op_b_p0      <= '0;
            alu_op_p0    <= '0;
            alu_shift_p0 <= '0;
        end else if (accept) begin
            op_a_p0      <= sel_op_a;
            op_b_p0      <= sel_op_b;
            alu_op_p0    <= sel_alu_op;
            alu_shift_p0 <= sel_alu_shift;
        end
    end

    // ---- result stage (p1): capture ALU outputs at the end of EXEC ----
    // Sample the shared ALU once, in the single EXEC cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_data_p1 <= '0;
            rsp_zero_p1 <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data_p1 <= i_alu_out;
            rsp_zero_p1 <= i_alu_zero;
        end
    end

    assign o_alu_op_a  = op_a_p0;
    assign o_alu_op_b  = op_b_p0;
    assign o_alu_op    = alu_op_p0;
    assign o_alu_shift = alu_shift_p0;

    assign o_rsp_data  = rsp_data_p1;
    assign o_rsp_zero  = rsp_zero_p1;
    assign o_rsp_valid = (state == RESP) ? (win_idx ? 2'b10 : 2'b01) : 2'b00;
    assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter with a behavioural shared ALU.
// ALU op encoding used by this bench's ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR,
// 5 SHIFT (shift code 0 SLL, 1 SRL, 2 SRA, 3 pass op_a); other ops give 0.

module tb_alu_share_arbiter;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SH  = 3'd5;
    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRA = 2'd2;

    logic                clk;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_op_a;
    logic [2*DATA_W-1:0] req_op_b;
    logic [5:0]          req_alu_op;
    logic [3:0]          req_alu_shift;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_zero;
    logic [DATA_W-1:0]   alu_op_a;
    logic [DATA_W-1:0]   alu_op_b;
    logic [2:0]          alu_op;
    logic [1:0]          alu_shift;
    logic [DATA_W-1:0]   alu_out;
    logic                alu_zero;
    logic                busy;

    int checks;
    int failures;

    alu_share_arbiter #(.DATA_W(DATA_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_op_a     (req_op_a),
        .i_req_op_b     (req_op_b),
        .i_req_alu_op   (req_alu_op),
        .i_req_alu_shift(req_alu_shift),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_zero     (rsp_zero),
        .o_alu_op_a     (alu_op_a),
        .o_alu_op_b     (alu_op_b),
        .o_alu_op       (alu_op),
        .o_alu_shift    (alu_shift),
        .i_alu_out      (alu_out),
        .i_alu_zero     (alu_zero),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU driven by the arbiter.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            OP_ADD: alu_out = alu_op_a + alu_op_b;
            OP_SUB: alu_out = alu_op_a - alu_op_b;
            OP_AND: alu_out = alu_op_a & alu_op_b;
            OP_OR:  alu_out = alu_op_a | alu_op_b;
            OP_XOR: alu_out = alu_op_a ^ alu_op_b;
            OP_SH: begin
                case (alu_shift)
                    2'd0:    alu_out = alu_op_a << alu_op_b[4:0];
                    2'd1:    alu_out = alu_op_a >> alu_op_b[4:0];
                    2'd2:    alu_out = $unsigned($signed(alu_op_a) >>> alu_op_b[4:0]);
                    default: alu_out = alu_op_a;
                endcase
            end
            default: alu_out = '0;
        endcase
    end
    assign alu_zero = (alu_out == '0);

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [2:0]  op0;
        logic [1:0]  sh0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [2:0]  op1;
        logic [1:0]  sh1;
        logic        win;
        logic [31:0] data;
        logic        zero;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [2:0] op0, input logic [1:0] sh0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [2:0] op1, input logic [1:0] sh1);
        req_valid     = v;
        req_op_a      = {a1, a0};
        req_op_b      = {b1, b0};
        req_alu_op    = {op1, op0};
        req_alu_shift = {sh1, sh0};
    endtask

    initial begin
        logic [1:0]  exp_rv;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  eop;
        logic [1:0]  esh;

        checks   = 0;
        failures = 0;

        //            valid  a0           b0           op0     sh0     a1           b1           op1     sh1     win   data         zero
        vt[0] = '{2'b11, 32'd7,       32'd7,       OP_SUB, 2'd0,   32'hF0,      32'h0F,      OP_OR,  2'd0,   1'b0, 32'h0,       1'b1};
        vt[1] = '{2'b11, 32'd7,       32'd7,       OP_SUB, 2'd0,   32'hF0,      32'h0F,      OP_OR,  2'd0,   1'b1, 32'hFF,      1'b0};
        vt[2] = '{2'b11, 32'hFF00FF00, 32'h0F0F0F0F, OP_AND, 2'd0, 32'h12345678, 32'hFFFFFFFF, OP_XOR, 2'd0, 1'b0, 32'h0F000F00, 1'b0};
        vt[3] = '{2'b11, 32'hFF00FF00, 32'h0F0F0F0F, OP_AND, 2'd0, 32'h12345678, 32'hFFFFFFFF, OP_XOR, 2'd0, 1'b1, 32'hEDCBA987, 1'b0};
        vt[4] = '{2'b01, 32'd5,       32'd3,       OP_ADD, 2'd0,   32'd0,       32'd0,       OP_ADD, 2'd0,   1'b0, 32'd8,       1'b0};
        vt[5] = '{2'b10, 32'd0,       32'd0,       OP_ADD, 2'd0,   32'h80000000, 32'd4,      OP_SH,  SH_SRA, 1'b1, 32'hF8000000, 1'b0};
        vt[6] = '{2'b01, 32'hFFFFFFFF, 32'd1,      OP_ADD, 2'd0,   32'd0,       32'd0,       OP_ADD, 2'd0,   1'b0, 32'h0,       1'b1};
        vt[7] = '{2'b10, 32'd0,       32'd0,       OP_ADD, 2'd0,   32'hDEADBEEF, 32'd9,      OP_SH,  2'd3,   1'b1, 32'hDEADBEEF, 1'b0};
        vt[8] = '{2'b01, 32'h1234,    32'h5678,    3'd7,   2'd1,   32'd0,       32'd0,       OP_ADD, 2'd0,   1'b0, 32'h0,       1'b1};
        vt[9] = '{2'b10, 32'd0,       32'd0,       OP_ADD, 2'd0,   32'd1,       32'd31,      OP_SH,  SH_SLL, 1'b1, 32'h80000000, 1'b0};

        // Reset state, with both requests pending during reset
        rst_n     = 1'b0;
        rsp_ready = 2'b00;
        drive(2'b11, 32'd1, 32'd2, OP_ADD, 2'd0, 32'd3, 32'd4, OP_ADD, 2'd0);
        tick();
        tick();
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  rsp_data,           32'd0);
        chk("rst_rsp_zero",  {31'd0, rsp_zero},  32'd0);
        chk("rst_alu_op_a",  alu_op_a,           32'd0);
        chk("rst_alu_op_b",  alu_op_b,           32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        tick();

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].valid, vt[i].a0, vt[i].b0, vt[i].op0, vt[i].sh0,
                  vt[i].a1, vt[i].b1, vt[i].op1, vt[i].sh1);
            exp_rv = vt[i].win ? 2'b10 : 2'b01;
            ea  = vt[i].win ? vt[i].a1  : vt[i].a0;
            eb  = vt[i].win ? vt[i].b1  : vt[i].b0;
            eop = vt[i].win ? vt[i].op1 : vt[i].op0;
            esh = vt[i].win ? vt[i].sh1 : vt[i].sh0;
            #1;
            chk($sformatf("v%0d_req_ready", i), {30'd0, req_ready}, {30'd0, exp_rv});
            tick();
            req_valid = 2'b00;
            #1;
            chk($sformatf("v%0d_exec_busy", i),  {31'd0, busy},      32'd1);
            chk($sformatf("v%0d_exec_ready", i), {30'd0, req_ready}, 32'd0);
            chk($sformatf("v%0d_exec_rspv", i),  {30'd0, rsp_valid}, 32'd0);
            chk($sformatf("v%0d_alu_a", i),      alu_op_a,           ea);
            chk($sformatf("v%0d_alu_b", i),      alu_op_b,           eb);
            chk($sformatf("v%0d_alu_op", i),     {29'd0, alu_op},    {29'd0, eop});
            chk($sformatf("v%0d_alu_shift", i),  {30'd0, alu_shift}, {30'd0, esh});
            tick();
            chk($sformatf("v%0d_rsp_valid", i),  {30'd0, rsp_valid}, {30'd0, exp_rv});
            chk($sformatf("v%0d_rsp_data", i),   rsp_data,           vt[i].data);
            chk($sformatf("v%0d_rsp_zero", i),   {31'd0, rsp_zero},  {31'd0, vt[i].zero});
            rsp_ready = exp_rv;
            tick();
            rsp_ready = 2'b00;
            chk($sformatf("v%0d_idle_busy", i),  {31'd0, busy},      32'd0);
            chk($sformatf("v%0d_idle_rspv", i),  {30'd0, rsp_valid}, 32'd0);
        end

        // Backpressure: req0 holds its result, req1 must wait without a grant
        drive(2'b11, 32'd5, 32'd3, OP_ADD, 2'd0, 32'hF0, 32'h0F, OP_OR, 2'd0);
        #1;
        chk("bp_grant0", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rspv_%0d", i),  {30'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp_data_%0d", i),  rsp_data,           32'd8);
            chk($sformatf("bp_ready_%0d", i), {30'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("bp_release_busy", {31'd0, busy},      32'd0);
        chk("bp_next_grant",   {30'd0, req_ready}, 32'd2);

        // Wrong-requester ready: req1 owns the result, req0's ready is ignored
        tick();
        req_valid = 2'b00;
        tick();
        rsp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wr_rspv_%0d", i), {30'd0, rsp_valid}, 32'd2);
            chk($sformatf("wr_data_%0d", i), rsp_data,           32'hFF);
            tick();
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        chk("wr_release_busy", {31'd0, busy}, 32'd0);

        // A request withdrawn before any edge is not granted
        drive(2'b01, 32'd1, 32'd1, OP_ADD, 2'd0, 32'd0, 32'd0, OP_ADD, 2'd0);
        #1;
        chk("drop_ready_on", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        #1;
        chk("drop_ready_off", {30'd0, req_ready}, 32'd0);
        tick();
        chk("drop_busy", {31'd0, busy}, 32'd0);

        // Reset during EXEC: grant req0 so the pointer would favour req1
        drive(2'b01, 32'd5, 32'd3, OP_ADD, 2'd0, 32'd0, 32'd0, OP_ADD, 2'd0);
        tick();
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'd0, busy},      32'd0);
        chk("mid_rst_rspv",  {30'd0, rsp_valid}, 32'd0);
        chk("mid_rst_data",  rsp_data,           32'd0);
        chk("mid_rst_ready", {30'd0, req_ready}, 32'd0);
        chk("mid_rst_alu_a", alu_op_a,           32'd0);
        tick();
        req_valid = 2'b00;
        rst_n     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst_rspv_%0d", i), {30'd0, rsp_valid}, 32'd0);
            chk($sformatf("post_rst_busy_%0d", i), {31'd0, busy},      32'd0);
        end
        drive(2'b11, 32'd5, 32'd3, OP_ADD, 2'd0, 32'hF0, 32'h0F, OP_OR, 2'd0);
        #1;
        chk("post_rst_tie", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        chk("post_rst_rspv", {30'd0, rsp_valid}, 32'd1);
        chk("post_rst_data", rsp_data,           32'd8);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
